pwm_multi: RTL and testbench
============================

# pwm_multi

Parametrised multi-channel PWM generator and successor to the single 8-bit PWM used by the RGB display. One shared counter drives CHANNELS comparators. The block adds configurable resolution, a clock prescaler, edge- or center-aligned modes, double-buffered duty registers that update only at period boundaries, and a period-start strobe. It sits between the colour/brightness control logic and the LED pins.

## Interface
- WIDTH, 8: counter and duty resolution in bits; M = 2^WIDTH-1.
- CHANNELS, 3: number of PWM outputs.
- PRESCALE_W, 8: prescaler compare width.
- SEL_W, $clog2(CHANNELS) (minimum 1): channel-select width.
- clk  in  1  single system clock; all logic is on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- prescale  in  PRESCALE_W  counter advances once every prescale+1 clocks.
- center_mode  in  1  0 = edge-aligned sawtooth, 1 = center-aligned triangle; latched at period boundary.
- duty_wr  in  1  one-cycle write strobe for a shadow duty register.
- duty_sel  in  SEL_W  channel index for the write.
- duty_in  in  WIDTH  duty value to write.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-clock pulse marking the first cycle of each period.

## Operation
- Prescaler pre_cnt:
  - tick = en && (pre_cnt >= prescale); on tick, pre_cnt <= 0, otherwise pre_cnt+1.
  - The >= compare makes a mid-count reduction of prescale wrap immediately.
  - prescale = 0 gives a tick every clock.
- Edge mode: cnt counts 0..M on ticks, then wraps M->0.
- Center mode: cnt counts 0 up to M, then down to 0, held in a dir register (up = 1). dir flips to down on the tick where cnt reaches M and to up on the tick where cnt reaches 0. Each of 0 and M is visited once per period.
- Boundary: the tick on which cnt_next == 0. On a boundary:
  - active_duty[i] <= shadow_duty[i] for every channel.
  - mode_q <= center_mode.
  - period_start asserts for one clock.
- Writes: on duty_wr with duty_sel < CHANNELS, shadow_duty[duty_sel] <= duty_in. Writes with an out-of-range duty_sel are ignored.
- Write on the boundary cycle: active takes the old shadow value. The new value applies from the next period.
- Compare: pwm_out[i] <= en && (cnt < active_duty[i]), unsigned WIDTH-bit compare.
- High time per period:
  - Edge mode: d ticks out of 2^WIDTH. Duty 0 is constant low; M gives M/2^WIDTH high.
  - Center mode: 2d-1 ticks out of 2M for d >= 1; 0 ticks for d = 0.
- Disabled (en = 0):
  - pre_cnt, cnt and dir are held at reset values and pwm_out is 0.
  - active_duty and mode_q track shadow_duty and center_mode every clock.
  - Writes are still accepted.
  - On re-enable, the first period starts at cnt = 0 with the latest values and period_start pulses.

## Timing
- Reset values: pre_cnt = 0, cnt = 0, dir = up, mode_q = 0, all shadow and active duties = 0, pwm_out = 0, period_start = 0.
- Reset mid-period clears everything immediately (asynchronously). Outputs are low until the first enabled period.
- pwm_out lags cnt by one clock, since the compare result is registered.
- period_start is registered and high during the same clock in which cnt reads 0 at the start of a period.
- Shadow-to-output latency: the write takes effect at the next boundary and appears on pwm_out one clock later.
- Period length in clocks:
  - Edge mode: 2^WIDTH*(prescale+1).
  - Center mode: 2*M*(prescale+1).
- Switching center_mode mid-period has no effect until the next boundary.
- First period after en rises: period_start pulses one clock after en is sampled high, then follows the period length.

## Test plan
All cases use WIDTH=8 and CHANNELS=3 unless stated otherwise.

- Reset with en=1, prescale=0 -> pwm_out=000 and period_start=0 during reset. After release, period_start pulses every 256 clocks and outputs stay 000 (duties 0).
- Edge mode, prescale=0, write duties 64/128/255 -> from the next period, high counts per 256-clock period are 64/128/255; duty 0 on a channel stays constant low.
- Center mode, prescale=1, duty 100 -> period = 1020 clocks, ch0 high for 199*2 = 398 clocks, symmetric about cnt=255; period_start pulses every 1020 clocks.
- Write duty 200 on the boundary cycle, then duty 50 mid-period -> the period starting at that boundary uses the old value; the next period uses 50. No glitch occurs within a period.
- duty_sel=3 write -> ignored. Toggle center_mode mid-period -> mode changes only at the boundary.
- Deassert en mid-period -> pwm_out=0 next clock and counters are held. Reassert -> period_start pulses and cnt restarts at 0. Assert nrst low mid-period -> all outputs are 0 immediately.

Source files
------------

// File: rtl/pwm_multi_if.sv
// Duty-register write port of pwm_multi: a one-cycle strobe with a channel
// index and the new duty value.
interface pwm_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic             duty_wr;
  logic [SEL_W-1:0] duty_sel;
  logic [WIDTH-1:0] duty_in;

  modport master (output duty_wr, duty_sel, duty_in);
  modport slave  (input  duty_wr, duty_sel, duty_in);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared prescaled counter (sawtooth or triangle)
// drives CHANNELS comparators with double-buffered duty registers.
module pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 3,
  parameter int PRESCALE_W = 8,
  parameter int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  center_mode,
  pwm_multi_if.slave            duty_bus,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start
);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  localparam logic [SEL_W:0] NUM_CH = CHANNELS[SEL_W:0];

  logic [PRESCALE_W-1:0] pre_cnt, pre_nxt;
  logic [WIDTH-1:0]      cnt, cnt_nxt;
  dir_t                  dir, dir_nxt;
  logic                  mode_q;
  logic                  en_q;
  logic                  tick, start, boundary, load;
  logic [WIDTH-1:0]      shadow_duty [CHANNELS];
  logic [WIDTH-1:0]      active_duty [CHANNELS];

  // The enable-rising cycle is spent at cnt = 0 so that period_start lines up
  // with the first count of the restarted period.
  always_comb begin
    start    = en && !en_q;
    tick     = en && en_q && (pre_cnt >= prescale);
    pre_nxt  = pre_cnt;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    if (!en) begin
      pre_nxt = '0;
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick) begin
      pre_nxt = '0;
      if (!mode_q) begin
        cnt_nxt = cnt + 1'b1;
        dir_nxt = DIR_UP;
      end else if (dir == DIR_UP) begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == '1) dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) dir_nxt = DIR_UP;
      end
    end else if (!start) begin
      pre_nxt = pre_cnt + 1'b1;
    end
    boundary = tick && (cnt_nxt == '0);
    load     = !en || start || boundary;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_q       <= 1'b0;
      en_q         <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow_duty[i] <= '0;
        active_duty[i] <= '0;
      end
    end else begin
      pre_cnt      <= pre_nxt;
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      en_q         <= en;
      period_start <= boundary || start;
      if (load) begin
        mode_q <= center_mode;
        for (int unsigned i = 0; i < CHANNELS; i++)
          active_duty[i] <= shadow_duty[i];
      end
      if (duty_bus.duty_wr && ({1'b0, duty_bus.duty_sel} < NUM_CH))
        shadow_duty[duty_bus.duty_sel] <= duty_bus.duty_in;
      for (int unsigned i = 0; i < CHANNELS; i++)
        pwm_out[i] <= en && (cnt < active_duty[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: random duty/mode traffic checked period by period
// against closed-form period length and high-time rules.
module tb_pwm_multi;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int PW = 8;
  localparam int SW = 2;
  localparam int M  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic [PW-1:0] prescale;
  logic          center_mode;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  int total = 0;
  int bad   = 0;

  pwm_multi_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) bus ();

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW), .SEL_W(SW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .prescale     (prescale),
    .center_mode  (center_mode),
    .duty_bus     (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: shadow registers as written, plus the values seen just before
  // each clock edge (what a boundary on that edge would capture).
  int   shadow_m    [CH];
  int   prev_shadow [CH];
  logic prev_mode, en_s, en_prev;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CH; i++) begin
        shadow_m[i]    <= 0;
        prev_shadow[i] <= 0;
      end
      prev_mode <= 1'b0;
      en_s      <= 1'b0;
      en_prev   <= 1'b0;
    end else begin
      en_prev   <= en_s;
      en_s      <= en;
      prev_mode <= center_mode;
      for (int i = 0; i < CH; i++) prev_shadow[i] <= shadow_m[i];
      if (bus.duty_wr && int'(bus.duty_sel) < CH)
        shadow_m[bus.duty_sel] <= int'(bus.duty_in);
    end
  end

  function automatic int exp_len(input bit m, input int p);
    return m ? 2 * M * (p + 1) : (M + 1) * (p + 1);
  endfunction

  function automatic int exp_high(input bit m, input int d, input int p);
    if (m) return (d == 0) ? 0 : (2 * d - 1) * (p + 1);
    return d * (p + 1);
  endfunction

  // Period monitor: pwm_out lags by one clock, so a period's outputs are the
  // samples from one clock after its period_start up to the next one.
  initial begin : monitor
    int   k;
    int   acc   [CH];
    int   rises [CH];
    int   exp_d [CH];
    int   exp_p;
    bit   exp_m;
    bit   valid;
    logic [CH-1:0] last_pwm;
    valid = 0; k = 0; exp_p = 0; exp_m = 0; last_pwm = '0;
    for (int i = 0; i < CH; i++) begin acc[i] = 0; rises[i] = 0; exp_d[i] = 0; end
    forever begin
      @(negedge clk);
      if (!nrst || !en_s) begin
        chk("off_pwm", pwm_out, 0);
        chk("off_ps", period_start, 0);
        valid = 0;
      end else begin
        if (!en_prev) chk("start_ps", period_start, 1);
        k++;
        if (valid)
          for (int i = 0; i < CH; i++) begin
            acc[i] += pwm_out[i];
            if (k >= 2 && pwm_out[i] && !last_pwm[i]) rises[i]++;
          end
        if (period_start) begin
          if (valid) begin
            chk("period_len", k, exp_len(exp_m, exp_p));
            for (int i = 0; i < CH; i++) begin
              chk($sformatf("high_ch%0d", i), acc[i], exp_high(exp_m, exp_d[i], exp_p));
              chk($sformatf("rises_ch%0d", i), rises[i], (exp_m && exp_d[i] >= 2) ? 1 : 0);
            end
          end
          valid = 1; k = 0;
          exp_m = prev_mode;
          exp_p = int'(prescale);
          for (int i = 0; i < CH; i++) begin
            acc[i] = 0; rises[i] = 0; exp_d[i] = prev_shadow[i];
          end
        end
        last_pwm = pwm_out;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wr(input int sel, input int val);
    step();
    bus.duty_wr  = 1'b1;
    bus.duty_sel = SW'(sel);
    bus.duty_in  = W'(val);
    step();
    bus.duty_wr  = 1'b0;
  endtask

  task automatic wait_ps(input int max_clk);
    int seen = 0;
    for (int n = 0; n < max_clk && seen == 0; n++) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    chk("ps_wait", seen, 1);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    nrst = 1'b0; en = 1'b1; prescale = '0; center_mode = 1'b0;
    bus.duty_wr = 1'b0; bus.duty_sel = '0; bus.duty_in = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    nrst = 1'b1;
    repeat (4) wait_ps(300);

    // Edge mode, three duties, then one channel to zero.
    wr(0, 64); wr(1, 128); wr(2, 255);
    repeat (3) wait_ps(600);
    wr(1, 0);
    repeat (2) wait_ps(600);

    // Center mode, prescale 1.
    step(); en = 1'b0; prescale = 8'd1; center_mode = 1'b1;
    wr(0, 100);
    step(); en = 1'b1;
    repeat (3) wait_ps(1100);

    // Write exactly on the boundary edge, then again mid-period.
    step(); en = 1'b0; prescale = '0; center_mode = 1'b0;
    step(); en = 1'b1;
    wait_ps(600);
    repeat (255) @(posedge clk);
    #2;
    bus.duty_wr = 1'b1; bus.duty_sel = 2'd0; bus.duty_in = 8'd200;
    step();
    bus.duty_wr = 1'b0;
    repeat (100) step();
    wr(0, 50);
    repeat (3) wait_ps(600);

    // Random writes (including out-of-range selects) and mode toggles.
    wr(3, 77);
    for (int r = 0; r < 14; r++) begin
      case ($urandom_range(0, 3))
        0, 1: wr($urandom_range(0, 3), $urandom_range(0, 255));
        2:    begin step(); center_mode = ~center_mode; end
        default: wr(3, $urandom_range(0, 255));
      endcase
      repeat ($urandom_range(20, 400)) step();
    end
    step(); center_mode = 1'b0;
    repeat (3) wait_ps(1200);

    // Disable mid-period, then re-enable.
    wr(2, 255);
    repeat (2) wait_ps(600);
    repeat (50) step();
    en = 1'b0;
    step();
    chk("dis_pwm", pwm_out, 0);
    repeat (7) step();
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reen_ps", period_start, 1);
    repeat (2) wait_ps(600);

    // Asynchronous reset mid-period while ch2 is high.
    repeat (40) step();
    @(negedge clk);
    chk("pre_arst_ch2", pwm_out[2], 1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_ps", period_start, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
